uart_wb_master: RTL

Debug-port bus initiator: receives command frames on the DEBUG_RX UART line and runs single Wishbone read/write cycles on the SoC bus, the same bus that wb_power_interface answers as a responder. It returns status and read data on DEBUG_TX. This lets a host poke the QCW control registers (start, cycle limit, phase shift, fault/halt status) without firmware involvement. It sits in the 160 MHz system domain, arbitrated onto the bus beside base_soc.

---
 rtl/uart_wb_master.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - UART debug port that runs single Wishbone read/write cycles
//
// Ports:
//   wb_clk_i            system clock
//   wb_rst_i            asynchronous active-low reset
//   rx_i / tx_o         8N1 UART command in / response out, idle high
//   wb_adr_o, wb_dat_o  bus address and write data (big-endian from the frame)
//   wb_dat_i, wb_ack_i  responder read data and acknowledge
//   wb_sel_o, wb_we_o   byte selects (all set during a cycle) and write enable
//   wb_cyc_o, wb_stb_o  cycle / strobe, driven identically
//   busy_o              high while a frame is being handled
module uart_wb_master #(
    parameter int CLK_DIV       = 1389,
    parameter int WB_TIMEOUT    = 255,
    parameter int FRAME_TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rx_i,
    output logic        tx_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam int TW = ($clog2(WB_TIMEOUT + 1) > 8) ? $clog2(WB_TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TMO = TW'(WB_TIMEOUT);
    localparam int FT = FRAME_TIMEOUT * CLK_DIV;
    localparam int FW = $clog2(FT + 1);
    localparam logic [FW-1:0] FT_M1 = FW'(FT - 1);

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    // Receiver: runs in every state so it stays aligned to the line.
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_tick, rx_done, rx_ferr;

    assign rx_tick = rx_busy && (rx_cnt == '0);
    assign rx_done = rx_tick && (rx_bit == 4'd9) && rx_s2;
    assign rx_ferr = rx_tick && (rx_bit == 4'd9) && !rx_s2;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_s3   <= 1'b1;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= 4'd0;
            rx_sh   <= 8'h00;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF_M1;
                    rx_bit  <= 4'd0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= DIV_M1;
                if (rx_bit == 4'd0) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_s2) rx_busy <= 1'b0;
                    else       rx_bit  <= 4'd1;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end
        end
    end

    function automatic logic [7:0] data_byte(input logic [1:0] k, input logic [31:0] d);
        case (k)
            2'd0:    return d[31:24];
            2'd1:    return d[23:16];
            2'd2:    return d[15:8];
            default: return d[7:0];
        endcase
    endfunction

    logic [2:0]    state;
    logic          is_write;
    logic [1:0]    byte_cnt;
    logic [31:0]   rdata;
    logic          cyc;
    logic [TW-1:0] tcnt;
    logic [FW-1:0] ftimer;
    logic [2:0]    resp_idx, resp_last;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;
    assign wb_sel_o = {4{cyc}};
    assign wb_we_o  = cyc & is_write;
    assign busy_o   = (state != S_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            wb_adr_o  <= 32'h0;
            wb_dat_o  <= 32'h0;
            rdata     <= 32'h0;
            cyc       <= 1'b0;
            tcnt      <= '0;
            ftimer    <= '0;
            resp_idx  <= 3'd0;
            resp_last <= 3'd0;
            tx_o      <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= 4'd0;
            tx_sh     <= 9'h1FF;
        end else begin
            case (state)
                S_IDLE: if (rx_done) begin
                    if (rx_sh == 8'h57 || rx_sh == 8'h52) begin
                        is_write <= (rx_sh == 8'h57);
                        byte_cnt <= 2'd0;
                        ftimer   <= '0;
                        state    <= S_ADDR;
                    end else begin
                        state     <= S_RESP;
                        tx_o      <= 1'b0;
                        tx_cnt    <= '0;
                        tx_bit    <= 4'd0;
                        tx_sh     <= {1'b1, NAK};
                        resp_idx  <= 3'd0;
                        resp_last <= 3'd0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_ferr) begin
                        state <= S_IDLE;
                    end else if (rx_done) begin
                        ftimer   <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == S_ADDR) wb_adr_o <= {wb_adr_o[23:0], rx_sh};
                        else                 wb_dat_o <= {wb_dat_o[23:0], rx_sh};
                        if (byte_cnt == 2'd3) begin
                            if (state == S_ADDR && is_write) begin
                                state <= S_DATA;
                            end else begin
                                state <= S_BUS;
                                cyc   <= 1'b1;
                                tcnt  <= '0;
                            end
                        end
                    end else if (rx_busy) begin
                        ftimer <= '0;
                    end else if (ftimer == FT_M1) begin
                        state <= S_IDLE;
                    end else begin
                        ftimer <= ftimer + 1'b1;
                    end
                end
                S_BUS: begin
                    // Ack is checked before the timeout so an ack on the last cycle wins.
                    if (wb_ack_i || tcnt == TMO) begin
                        cyc       <= 1'b0;
                        state     <= S_RESP;
                        tx_o      <= 1'b0;
                        tx_cnt    <= '0;
                        tx_bit    <= 4'd0;
                        tx_sh     <= {1'b1, wb_ack_i ? ACK : NAK};
                        resp_idx  <= 3'd0;
                        resp_last <= (wb_ack_i && !is_write) ? 3'd4 : 3'd0;
                        if (wb_ack_i) rdata <= wb_dat_i;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (tx_cnt != DIV_M1) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            if (resp_idx == resp_last) begin
                                state <= S_IDLE;
                            end else begin
                                resp_idx <= resp_idx + 3'd1;
                                tx_bit   <= 4'd0;
                                tx_o     <= 1'b0;
                                tx_sh    <= {1'b1, data_byte(resp_idx[1:0], rdata)};
                            end
                        end else begin
                            // Shift out data bits, then the stop bit from the top of tx_sh.
                            tx_o   <= tx_sh[0];
                            tx_sh  <= {1'b1, tx_sh[8:1]};
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
